// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline applying one of eight bitwise gates.
// Define LOGIC_GATE_PIPE_REDUCE_EN to add registered Y_RAND/Y_ROR/Y_RXOR flags.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Y_ZERO,
    output logic [CNT_W-1:0] COUNT
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    ,
    output logic             Y_RAND,
    output logic             Y_ROR,
    output logic             Y_RXOR
`endif
);

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    logic             rand_q, rand_d;
    logic             ror_q, ror_d;
    logic             rxor_q, rxor_d;
`endif

    logic             s2_load;
    logic             s1_load;
    logic [WIDTH-1:0] gate_y;

    // Stage advance: S2 moves when empty or drained, S1 moves when S2 makes room.
    always_comb begin
        s2_load = !v2_q || OUT_READY;
        s1_load = !v1_q || s2_load;
    end

    assign IN_READY = s1_load;

    // Gate function evaluated on the S1 operands.
    always_comb begin
        gate_y = '0;
        case (op_q)
            3'd0:    gate_y = a_q & b_q;
            3'd1:    gate_y = a_q | b_q;
            3'd2:    gate_y = ~(a_q & b_q);
            3'd3:    gate_y = ~(a_q | b_q);
            3'd4:    gate_y = a_q ^ b_q;
            3'd5:    gate_y = ~(a_q ^ b_q);
            3'd6:    gate_y = ~a_q;
            default: gate_y = b_q;
        endcase
    end

    // Next-state for both stages and the delivered-result counter.
    always_comb begin
        v1_d  = v1_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        v2_d  = v2_q;
        y_d   = y_q;
        z_d   = z_q;
        cnt_d = cnt_q;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
        rand_d = rand_q;
        ror_d  = ror_q;
        rxor_d = rxor_q;
`endif
        if (s1_load) begin
            v1_d = IN_VALID;
            if (IN_VALID) begin
                a_d  = A;
                b_d  = B;
                op_d = OP;
            end
        end
        if (s2_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                y_d = gate_y;
                z_d = (gate_y == '0);
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
                rand_d = &gate_y;
                ror_d  = |gate_y;
                rxor_d = ^gate_y;
`endif
            end
        end
        if (v2_q && OUT_READY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            v2_q  <= 1'b0;
            y_q   <= '0;
            z_q   <= 1'b0;
            cnt_q <= '0;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
            rand_q <= 1'b0;
            ror_q  <= 1'b0;
            rxor_q <= 1'b0;
`endif
        end else begin
            v1_q  <= v1_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            v2_q  <= v2_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
            rand_q <= rand_d;
            ror_q  <= ror_d;
            rxor_q <= rxor_d;
`endif
        end
    end

    assign OUT_VALID = v2_q;
    assign Y         = y_q;
    assign Y_ZERO    = z_q;
    assign COUNT     = cnt_q;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    assign Y_RAND    = rand_q;
    assign Y_ROR     = ror_q;
    assign Y_RXOR    = rxor_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed and random stimulus against a timestamped queue model.
// Reduction-flag checks are compiled in when LOGIC_GATE_PIPE_REDUCE_EN is defined.
module tb_logic_gate_pipe;

    localparam int W = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [2:0]    OP = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [W-1:0]  Y;
    logic          Y_ZERO;
    logic [CW-1:0] COUNT;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    logic          Y_RAND;
    logic          Y_ROR;
    logic          Y_RXOR;
`endif

    logic_gate_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .A(A),
        .B(B),
        .OP(OP),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .Y(Y),
        .Y_ZERO(Y_ZERO),
        .COUNT(COUNT)
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
        ,
        .Y_RAND(Y_RAND),
        .Y_ROR(Y_ROR),
        .Y_RXOR(Y_RXOR)
`endif
    );

    always #5 CLK = ~CLK;

    // Model: each accepted item carries its acceptance edge and the
    // edge after which it is first visible at the output.
    typedef struct {
        logic [W-1:0] y;
        int           acc;
        int           vis;
    } item_t;

    item_t        q[$];
    logic [W-1:0] golden[$];
    int           edge_n = 0;
    int           cnt = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    function automatic logic [W-1:0] gate(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            RST = 1'b1;
            IN_VALID = 1'b0;
            @(posedge CLK);
            edge_n++;
        end
        q.delete();
        golden.delete();
        cnt = 0;
        #1;
        chk("rst_out_valid", 16'(OUT_VALID), 16'(0));
        chk("rst_y", 16'(Y), 16'(0));
        chk("rst_y_zero", 16'(Y_ZERO), 16'(0));
        chk("rst_count", 16'(COUNT), 16'(0));
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
        chk("rst_rand", 16'(Y_RAND), 16'(0));
        chk("rst_ror", 16'(Y_ROR), 16'(0));
        chk("rst_rxor", 16'(Y_RXOR), 16'(0));
`endif
    endtask

    task automatic step(input logic iv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op,
                        input logic ordy);
        logic exp_ir;
        logic exp_ov;
        logic in_x;
        logic out_x;
        logic [W-1:0] ey;
        item_t it;
        @(negedge CLK);
        RST = 1'b0;
        IN_VALID = iv;
        A = a;
        B = b;
        OP = op;
        OUT_READY = ordy;
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (q[0].vis <= edge_n);
        chk("in_ready", 16'(IN_READY), 16'(exp_ir));
        chk("out_valid", 16'(OUT_VALID), 16'(exp_ov));
        chk("count", 16'(COUNT), 16'(cnt % (1 << CW)));
        if (exp_ov) begin
            ey = q[0].y;
            chk("y", 16'(Y), 16'(ey));
            chk("y_zero", 16'(Y_ZERO), 16'(ey == 0));
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
            chk("y_rand", 16'(Y_RAND), 16'(ey == {W{1'b1}}));
            chk("y_ror", 16'(Y_ROR), 16'(ey != 0));
            chk("y_rxor", 16'(Y_RXOR), 16'($countones(ey) % 2));
`endif
        end
        in_x = iv && exp_ir;
        out_x = exp_ov && ordy;
        if (out_x && golden.size() > 0) begin
            chk("golden_y", 16'(Y), 16'(golden.pop_front()));
        end
        @(posedge CLK);
        edge_n++;
        if (out_x) begin
            void'(q.pop_front());
            cnt++;
            if (q.size() > 0) begin
                q[0].vis = (q[0].acc + 1 > edge_n) ? q[0].acc + 1 : edge_n;
            end
        end
        if (in_x) begin
            it.y = gate(op, a, b);
            it.acc = edge_n;
            it.vis = (q.size() == 0) ? edge_n + 1 : 0;
            q.push_back(it);
        end
    endtask

    initial begin
        logic [W-1:0] tbl[8];
        tbl = '{8'h4A, 8'hDF, 8'hB5, 8'h20, 8'h95, 8'h6A, 8'h35, 8'h5F};

        // Reset, then idle.
        do_reset(2);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // All eight ops back to back.
        for (int i = 0; i < 8; i++) begin
            golden.push_back(tbl[i]);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'hCA, 8'h5F, 3'(i), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        chk("ops_all_delivered", 16'(golden.size()), 16'(0));

        // Zero result.
        golden.push_back(8'h00);
        step(1'b1, 8'hF0, 8'h0F, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        chk("zero_delivered", 16'(golden.size()), 16'(0));

        // Backpressure: third push stalls until OUT_READY rises.
        step(1'b1, 8'h11, 8'h22, 3'd1, 1'b0);
        step(1'b1, 8'h33, 8'h44, 3'd4, 1'b0);
        step(1'b1, 8'h55, 8'h66, 3'd2, 1'b0);
        step(1'b1, 8'h55, 8'h66, 3'd2, 1'b0);
        step(1'b1, 8'h55, 8'h66, 3'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end

        // Counter wrap: 17 deliveries from zero.
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 8'(i * 3), 3'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        #1;
        chk("count_wrap", 16'(COUNT), 16'(1));

        // Reset while full and stalled; nothing stale may emerge.
        step(1'b1, 8'hAA, 8'h0F, 3'd0, 1'b0);
        step(1'b1, 8'hBB, 8'hF0, 3'd1, 1'b0);
        step(1'b1, 8'hCC, 8'h3C, 3'd5, 1'b0);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 3'($urandom), 1'(($urandom % 4) != 0));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        end
        chk("drained", 16'(q.size()), 16'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
